unpack_data: RTL and testbench



---
 rtl/pcie_phy_pkg.sv | 24 ++
 rtl/unpack_beat_select.sv | 67 ++++++
 rtl/unpack_data.sv | 156 +++++++++++++++
 tb/tb_unpack_data.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_phy_pkg.sv
// rtl/pcie_phy_pkg.sv - shared PHY rate types, symbols and TX unpacker definitions
package pcie_phy_pkg;

  typedef enum logic [2:0] {
    RATE_GEN1 = 3'd0,
    RATE_GEN2 = 3'd1,
    RATE_GEN3 = 3'd2,
    RATE_GEN4 = 3'd3,
    RATE_GEN5 = 3'd4
  } rate_speed_e;

  localparam logic [7:0] ENDP = 8'hFD;

  localparam logic [1:0] SyncHdrData = 2'b10;
  localparam logic [1:0] SyncHdrNone = 2'b00;

  localparam int BytesPerTransaction = 64;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND_DATA = 2'd1
  } unpack_st_e;

endpackage

// File: rtl/unpack_beat_select.sv
// rtl/unpack_beat_select.sv - picks one lane beat out of a packed transaction
// Logical lane l owns beat bytes l*lane_bytes.. ; reverse mirrors lanes within the active set.
module unpack_beat_select
  import pcie_phy_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_NUM_LANES = 4,
  parameter int PKT_WIDTH     = 512
) (
  input  logic [PKT_WIDTH-1:0]                pkt_data,
  input  logic [PKT_WIDTH/8-1:0]              pkt_k,
  input  logic [6:0]                          beat_idx,
  input  logic [7:0]                          bytes_per_beat,
  input  logic [5:0]                          num_lanes,
  input  logic [2:0]                          lane_bytes,
  input  logic                                lane_reverse,
  output logic [MAX_NUM_LANES*DATA_WIDTH-1:0] beat_data,
  output logic [4*MAX_NUM_LANES-1:0]          beat_k,
  output logic                                endp_found
);

  localparam int BeatBytes = 4 * MAX_NUM_LANES;
  localparam int PktBytes  = PKT_WIDTH / 8;
  localparam int PktByteW  = $clog2(PktBytes);
  localparam int BeatByteW = $clog2(BeatBytes);

  int                   base;
  int                   src;
  int                   dst;
  int                   lane_dst;
  logic [PktByteW-1:0]  src_byte;
  logic [BeatByteW-1:0] dst_byte;
  logic [7:0]           byte_val;

  always_comb begin
    beat_data  = '0;
    beat_k     = '0;
    endp_found = 1'b0;
    src        = 0;
    dst        = 0;
    lane_dst   = 0;
    src_byte   = '0;
    dst_byte   = '0;
    byte_val   = '0;
    base       = int'(beat_idx) * int'(bytes_per_beat);
    for (int l = 0; l < MAX_NUM_LANES; l++) begin
      for (int o = 0; o < BeatBytes; o++) begin
        src      = l * int'(lane_bytes) + o;
        lane_dst = lane_reverse ? int'(num_lanes) - 1 - l : l;
        dst      = lane_dst * int'(lane_bytes) + o;
        // Bytes past the end of the transaction are left as zero padding.
        if (l < int'(num_lanes) && o < int'(lane_bytes) && src < int'(bytes_per_beat) &&
            dst >= 0 && dst < BeatBytes && base + src < PktBytes) begin
          src_byte = PktByteW'(base + src);
          dst_byte = BeatByteW'(dst);
          byte_val = pkt_data[{src_byte, 3'b000} +: 8];
          beat_data[{dst_byte, 3'b000} +: 8] = byte_val;
          beat_k[dst_byte] = pkt_k[src_byte];
          if (byte_val == ENDP && !pkt_k[src_byte]) begin
            endp_found = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/unpack_data.sv
// rtl/unpack_data.sv - slices a packed TX transaction into per-cycle lane beats
// Beat 0 of a new packet may follow the last beat of the previous one with no bubble.
module unpack_data
  import pcie_phy_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_NUM_LANES = 4,
  parameter int PKT_WIDTH     = 512
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                phy_link_up_i,
  input  logic                                lane_reverse_i,
  input  rate_speed_e                         curr_data_rate_i,
  input  logic [5:0]                          pipe_width_i,
  input  logic [5:0]                          num_active_lanes_i,
  input  logic [PKT_WIDTH-1:0]                pkt_data_i,
  input  logic [PKT_WIDTH/8-1:0]              pkt_k_i,
  input  logic                                pkt_valid_i,
  output logic                                pkt_ready_o,
  output logic [MAX_NUM_LANES*DATA_WIDTH-1:0] data_o,
  output logic [MAX_NUM_LANES-1:0]            data_valid_o,
  output logic [4*MAX_NUM_LANES-1:0]          data_k_o,
  output logic [2*MAX_NUM_LANES-1:0]          sync_header_o,
  input  logic                                data_ready_i
);

  localparam int BeatBytes = 4 * MAX_NUM_LANES;

  unpack_st_e                         state;
  logic [6:0]                         beat_cnt;
  logic [PKT_WIDTH-1:0]               shadow_data;
  logic [PKT_WIDTH/8-1:0]             shadow_k;
  logic                               cur_endp;

  logic [2:0]                         lane_bytes;
  logic [7:0]                         bytes_per_beat;
  logic                               b_legal;
  logic [14:0]                        next_offset;
  logic                               beat_last;
  logic                               beat_accept;
  logic                               pkt_accept;

  logic [6:0]                         sel_idx;
  logic [PKT_WIDTH-1:0]               sel_src_data;
  logic [PKT_WIDTH/8-1:0]             sel_src_k;
  logic [MAX_NUM_LANES*DATA_WIDTH-1:0] sel_data;
  logic [4*MAX_NUM_LANES-1:0]         sel_k;
  logic                               sel_endp;
  logic [MAX_NUM_LANES-1:0]           lane_mask;
  logic [2*MAX_NUM_LANES-1:0]         sync_hdr;

  assign lane_bytes     = 3'(pipe_width_i >> 3);
  assign bytes_per_beat = 8'(num_active_lanes_i) * {5'd0, lane_bytes};
  assign b_legal        = (bytes_per_beat != 8'd0) && (bytes_per_beat <= 8'(BeatBytes));

  assign next_offset = (15'(beat_cnt) + 15'd1) * 15'(bytes_per_beat);
  assign beat_last   = cur_endp || (next_offset >= 15'(BytesPerTransaction));
  assign beat_accept = (state == ST_SEND_DATA) && (data_valid_o != '0) && data_ready_i;

  assign pkt_ready_o = phy_link_up_i && b_legal &&
                       ((state == ST_IDLE) || (beat_accept && beat_last));
  assign pkt_accept  = pkt_valid_i && pkt_ready_o;

  // A freshly accepted packet is sliced straight from the input bus.
  assign sel_idx      = pkt_accept ? 7'd0 : beat_cnt + 7'd1;
  assign sel_src_data = pkt_accept ? pkt_data_i : shadow_data;
  assign sel_src_k    = pkt_accept ? pkt_k_i : shadow_k;

  unpack_beat_select #(
    .DATA_WIDTH    (DATA_WIDTH),
    .MAX_NUM_LANES (MAX_NUM_LANES),
    .PKT_WIDTH     (PKT_WIDTH)
  ) u_beat_select (
    .pkt_data       (sel_src_data),
    .pkt_k          (sel_src_k),
    .beat_idx       (sel_idx),
    .bytes_per_beat (bytes_per_beat),
    .num_lanes      (num_active_lanes_i),
    .lane_bytes     (lane_bytes),
    .lane_reverse   (lane_reverse_i),
    .beat_data      (sel_data),
    .beat_k         (sel_k),
    .endp_found     (sel_endp)
  );

  always_comb begin
    lane_mask = '0;
    sync_hdr  = '0;
    for (int l = 0; l < MAX_NUM_LANES; l++) begin
      lane_mask[l] = (6'(l) < num_active_lanes_i);
      if (lane_mask[l] && curr_data_rate_i >= RATE_GEN3) begin
        sync_hdr[2*l +: 2] = SyncHdrData;
      end else begin
        sync_hdr[2*l +: 2] = SyncHdrNone;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (pkt_accept) begin
      shadow_data <= pkt_data_i;
      shadow_k    <= pkt_k_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !phy_link_up_i) begin
      state         <= ST_IDLE;
      beat_cnt      <= '0;
      cur_endp      <= 1'b0;
      data_o        <= '0;
      data_valid_o  <= '0;
      data_k_o      <= '0;
      sync_header_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pkt_accept) begin
            state         <= ST_SEND_DATA;
            beat_cnt      <= '0;
            cur_endp      <= sel_endp;
            data_o        <= sel_data;
            data_valid_o  <= lane_mask;
            data_k_o      <= sel_k;
            sync_header_o <= sync_hdr;
          end
        end
        ST_SEND_DATA: begin
          if (beat_accept) begin
            if (pkt_accept || !beat_last) begin
              beat_cnt      <= pkt_accept ? 7'd0 : beat_cnt + 7'd1;
              cur_endp      <= sel_endp;
              data_o        <= sel_data;
              data_valid_o  <= lane_mask;
              data_k_o      <= sel_k;
              sync_header_o <= sync_hdr;
            end else begin
              state         <= ST_IDLE;
              beat_cnt      <= '0;
              cur_endp      <= 1'b0;
              data_o        <= '0;
              data_valid_o  <= '0;
              data_k_o      <= '0;
              sync_header_o <= '0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unpack_data.sv
// tb/tb_unpack_data.sv - self-checking bench for unpack_data
module tb_unpack_data;
  import pcie_phy_pkg::*;

  localparam int DW = 32;
  localparam int NL = 4;
  localparam int PW = 512;
  localparam logic [7:0] ENDP_SYM = 8'hFD;

  logic              clk = 1'b0;
  logic              rst;
  logic              link;
  logic              rev;
  rate_speed_e       rate;
  logic [5:0]        pipe_w;
  logic [5:0]        n_lanes;
  logic [PW-1:0]     pdata;
  logic [PW/8-1:0]   pk;
  logic              pvalid;
  logic              prdy;
  logic [NL*DW-1:0]  dout;
  logic [NL-1:0]     dvalid;
  logic [4*NL-1:0]   dk;
  logic [2*NL-1:0]   sh;
  logic              dready;

  always #5 clk = ~clk;

  unpack_data #(.DATA_WIDTH(DW), .MAX_NUM_LANES(NL), .PKT_WIDTH(PW)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .phy_link_up_i      (link),
    .lane_reverse_i     (rev),
    .curr_data_rate_i   (rate),
    .pipe_width_i       (pipe_w),
    .num_active_lanes_i (n_lanes),
    .pkt_data_i         (pdata),
    .pkt_k_i            (pk),
    .pkt_valid_i        (pvalid),
    .pkt_ready_o        (prdy),
    .data_o             (dout),
    .data_valid_o       (dvalid),
    .data_k_o           (dk),
    .sync_header_o      (sh),
    .data_ready_i       (dready)
  );

  typedef struct packed {
    logic [NL*DW-1:0] d;
    logic [4*NL-1:0]  k;
    logic [NL-1:0]    v;
    logic [2*NL-1:0]  s;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    beats_acc = 0;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void timeout_fail(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endfunction

  function automatic int bytes_pb();
    return int'(n_lanes) * int'(pipe_w >> 3);
  endfunction

  // Whole-packet model: expected beats computed up front from byte offsets.
  function automatic void push_pkt(logic [PW-1:0] d, logic [PW/8-1:0] kk);
    int w = int'(pipe_w >> 3);
    int n = int'(n_lanes);
    int b = n * w;
    for (int beat = 0; beat < 64; beat++) begin
      beat_t e;
      bit    endp;
      e    = '0;
      endp = 1'b0;
      for (int i = 0; i < b; i++) begin
        int g = beat * b + i;
        int l = i / w;
        int p = (rev ? n - 1 - l : l) * w + i % w;
        if (g < 64) begin
          e.d[8*p +: 8] = d[8*g +: 8];
          e.k[p] = kk[g];
          if (d[8*g +: 8] == ENDP_SYM && !kk[g]) endp = 1'b1;
        end
      end
      for (int l = 0; l < n; l++) begin
        e.v[l] = 1'b1;
        e.s[2*l +: 2] = (rate >= RATE_GEN3) ? 2'b10 : 2'b00;
      end
      exp_q.push_back(e);
      if ((beat + 1) * b >= 64 || endp) break;
    end
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else begin
        int b     = bytes_pb();
        bit legal = (b >= 1) && (b <= 4 * NL);
        bit erdy  = link && legal && (exp_q.size() == 0 || (exp_q.size() == 1 && dready));
        chk("pkt_ready", 256'(prdy), 256'(erdy));
        if (exp_q.size() == 0) begin
          chk("idle_valid", 256'(dvalid), 256'(0));
        end else begin
          chk("beat", 256'({dout, dk, dvalid, sh}), 256'(exp_q[0]));
          if (dready) begin
            void'(exp_q.pop_front());
            beats_acc++;
          end
        end
        if (!link) exp_q.delete();
        else if (pvalid && prdy) push_pkt(pdata, pk);
      end
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [PW-1:0] d, input logic [PW/8-1:0] kk, input bit hold,
                      input string name, output int cycles);
    bit acc = 1'b0;
    cycles = 0;
    pdata  = d;
    pk     = kk;
    pvalid = 1'b1;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = prdy;
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!acc) timeout_fail(name);
    if (!hold) pvalid = 1'b0;
  endtask

  task automatic wait_drain(string name);
    bit done = 1'b0;
    for (int t = 0; t < 500 && !done; t++) begin
      if (exp_q.size() == 0 && dvalid == '0) done = 1'b1;
      else cyc(1);
    end
    if (!done) timeout_fail(name);
  endtask

  function automatic void make_pkt(int seed, output logic [PW-1:0] d, output logic [PW/8-1:0] kk);
    for (int i = 0; i < 64; i++) begin
      d[8*i +: 8] = 8'((seed * 37 + i * 5) & 8'h7F);
      kk[i]       = ((i + seed) % 9 == 0);
    end
  endfunction

  initial begin
    logic [PW-1:0]   d;
    logic [PW/8-1:0] kk;
    logic [PW-1:0]   d2;
    logic [PW/8-1:0] kk2;
    int              c;
    int              b0;

    rst = 1'b1; link = 1'b1; rev = 1'b0; rate = RATE_GEN1;
    pipe_w = 6'd8; n_lanes = 6'd1; pvalid = 1'b0; dready = 1'b1;
    pdata = '0; pk = '0;
    fork monitor(); join_none
    cyc(3);
    chk("reset_outputs", 256'({dout, dk, dvalid, sh}), 256'(0));
    chk("reset_ready", 256'(prdy), 256'(1));
    rst = 1'b0;
    cyc(1);

    // x1 pipe 8: one byte per beat, ENDP with K=1 must not end the packet.
    make_pkt(1, d, kk);
    d[8*10 +: 8] = ENDP_SYM;
    kk[10] = 1'b1;
    b0 = beats_acc;
    send(d, kk, 1'b0, "t1_accept", c);
    chk("t1_beat0_byte", 256'(dout[7:0]), 256'(d[7:0]));
    chk("t1_beat0_valid", 256'(dvalid), 256'(4'b0001));
    chk("t1_beat0_sync", 256'(sh), 256'(0));
    wait_drain("t1_drain");
    chk("t1_beats", 256'(beats_acc - b0), 256'(64));

    // x4 pipe 32: back-to-back packets with pkt_valid held.
    n_lanes = 6'd4; pipe_w = 6'd32;
    make_pkt(2, d, kk);
    make_pkt(3, d2, kk2);
    b0 = beats_acc;
    send(d, kk, 1'b1, "t2_accept_a", c);
    send(d2, kk2, 1'b0, "t2_accept_b", c);
    chk("t2_accept_gap", 256'(c), 256'(4));
    chk("t2_b_beat0", 256'(dout), 256'(d2[127:0]));
    wait_drain("t2_drain");
    chk("t2_beats", 256'(beats_acc - b0), 256'(8));

    // x1 pipe 32 with ENDP at byte 5: two beats only.
    n_lanes = 6'd1;
    make_pkt(4, d, kk);
    d[8*5 +: 8] = ENDP_SYM;
    kk[5] = 1'b0;
    b0 = beats_acc;
    send(d, kk, 1'b0, "t3_accept", c);
    wait_drain("t3_drain");
    chk("t3_beats", 256'(beats_acc - b0), 256'(2));
    chk("t3_idle_valid", 256'(dvalid), 256'(0));

    // x3 pipe 32 at 8 GT/s: partial last beat.
    n_lanes = 6'd3; rate = RATE_GEN3;
    make_pkt(5, d, kk);
    b0 = beats_acc;
    send(d, kk, 1'b0, "t4_accept", c);
    chk("t4_sync", 256'(sh), 256'(8'b00101010));
    cyc(5);
    chk("t4_last_lo", 256'(dout[31:0]), 256'(d[511:480]));
    chk("t4_last_hi", 256'(dout[127:32]), 256'(0));
    wait_drain("t4_drain");
    chk("t4_beats", 256'(beats_acc - b0), 256'(6));

    // B=16 with a three-cycle stall on beat 1.
    n_lanes = 6'd4;
    make_pkt(6, d, kk);
    b0 = beats_acc;
    send(d, kk, 1'b0, "t5_accept", c);
    cyc(1);
    dready = 1'b0;
    cyc(3);
    chk("t5_hold_byte", 256'(dout[7:0]), 256'(d[8*16 +: 8]));
    dready = 1'b1;
    cyc(1);
    chk("t5_next_byte", 256'(dout[7:0]), 256'(d[8*32 +: 8]));
    wait_drain("t5_drain");
    chk("t5_beats", 256'(beats_acc - b0), 256'(4));

    // x4 pipe 8 reversed, link drop during beat 3.
    pipe_w = 6'd8; rev = 1'b1; rate = RATE_GEN1;
    make_pkt(7, d, kk);
    send(d, kk, 1'b0, "t6_accept", c);
    chk("t6_rev_hi", 256'(dout[31:24]), 256'(d[7:0]));
    chk("t6_rev_lo", 256'(dout[7:0]), 256'(d[31:24]));
    cyc(3);
    link = 1'b0;
    cyc(1);
    chk("t6_down_outputs", 256'({dout, dk, dvalid, sh}), 256'(0));
    pvalid = 1'b1;
    cyc(2);
    chk("t6_down_ready", 256'(prdy), 256'(0));
    link = 1'b1;
    pvalid = 1'b0;
    cyc(2);
    rev = 1'b0;

    // Illegal beat widths keep pkt_ready low.
    n_lanes = 6'd4; pipe_w = 6'd40;
    pvalid = 1'b1;
    cyc(2);
    chk("t7_b20_ready", 256'(prdy), 256'(0));
    n_lanes = 6'd0; pipe_w = 6'd8;
    cyc(2);
    chk("t7_b0_ready", 256'(prdy), 256'(0));
    pvalid = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
